gcd_operand_frontend: RTL and testbench

Upstream feeder for the GCD core (controller plus datapath). It accepts operand pairs over a valid/ready interface and buffers them in a small FIFO. It launches one GCD computation at a time by holding the core's start high with stable operands, then captures the core result into a valid/ready output slot. This decouples the producer from the core's variable, data-dependent latency.

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_pair_fifo.sv | 65 ++++++
 rtl/gcd_operand_frontend.sv | 149 ++++++++++++++
 tb/tb_gcd_operand_frontend.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand front end: default width and launch FSM states.
package gcd_pkg;

    localparam int unsigned GcdWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of {a,b} operand pairs; DEPTH must be a power of two so the
// pointers wrap naturally.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GcdWidth,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a,
    input  logic [WIDTH-1:0] push_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head_a,
    output logic [WIDTH-1:0] head_b,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_a, push_b};
        end
    end

    assign {head_a, head_b} = mem_q[rd_ptr_q];

endmodule

// File: rtl/gcd_operand_frontend.sv
// Buffers operand pairs, launches one GCD core job at a time and holds the result.
// Define GCD_ZERO_BYPASS_EN to answer pairs with a zero operand without the core.
module gcd_operand_frontend
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GcdWidth,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    gcd_state_e       state_q, state_d;
    logic             core_start_q, core_start_d;
    logic [WIDTH-1:0] core_a_q, core_a_d;
    logic [WIDTH-1:0] core_b_q, core_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             first_q, first_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             bypass;

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_valid),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (fifo_pop),
        .head_a (head_a),
        .head_b (head_b),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign in_ready = !fifo_full;

`ifdef GCD_ZERO_BYPASS_EN
    assign bypass = (head_a == '0) || (head_b == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_start_d = core_start_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        first_d      = first_q;
        fifo_pop     = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Registered res_valid gates the launch: one result outstanding at most.
                if (!fifo_empty && !res_valid_q) begin
                    fifo_pop = 1'b1;
                    if (bypass) begin
                        res_data_d  = head_a | head_b;
                        res_valid_d = 1'b1;
                    end else begin
                        core_a_d     = head_a;
                        core_b_d     = head_b;
                        core_start_d = 1'b1;
                        first_d      = 1'b1;
                        state_d      = StRun;
                    end
                end
            end
            StRun: begin
                first_d = 1'b0;
                // A done seen in the first start cycle is stale from the core's last job.
                if (!first_q && core_done) begin
                    res_data_d   = core_result;
                    res_valid_d  = 1'b1;
                    core_start_d = 1'b0;
                    state_d      = StDrain;
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d      = StIdle;
                core_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            first_q      <= first_d;
        end
    end

    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

`ifndef SYNTHESIS
    // Operands must not move under a running computation.
    a_hold_operands: assert property (@(posedge clk) disable iff (rst)
        (state_q == StRun && state_d == StRun) |=> ($stable(core_a_q) && $stable(core_b_q)));
    a_single_result: assert property (@(posedge clk) disable iff (rst)
        res_valid_q |-> !fifo_pop);
`endif

endmodule

// File: tb/tb_gcd_operand_frontend.sv
// Bench for gcd_operand_frontend: behavioural GCD core model, queue scoreboard,
// table-driven single jobs, hand-written corner sequences and a random stream.
module tb_gcd_operand_frontend;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             core_start;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_done = 1'b0;
    logic [WIDTH-1:0] core_result = '0;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    always #5 clk = ~clk;

    gcd_operand_frontend #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               lat;
        logic [WIDTH-1:0] exp;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;
    int fixed_lat   = 3;
    int cur_lat     = 1;
    int core_cnt    = 0;
    int launches    = 0;
    bit stream_done = 1'b0;

    logic [WIDTH-1:0] exp_res_q[$];
    logic [WIDTH-1:0] got_q[$];
    pair_t            launch_q[$];
    bit               prev_start = 1'b0;
    logic [WIDTH-1:0] prev_a = '0;
    logic [WIDTH-1:0] prev_b = '0;

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[WIDTH-1:0];
    endfunction

    function automatic bit is_bypassed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef GCD_ZERO_BYPASS_EN
        return (a == 0) || (b == 0);
`else
        return (a != a) && (b != b);
`endif
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model: done after cur_lat start cycles, held until start drops.
    always @(posedge clk) begin
        #1;
        if (core_start !== 1'b1) begin
            core_cnt  = 0;
            core_done = 1'b0;
        end else begin
            if (core_cnt == 0) begin
                cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            end
            core_cnt++;
            core_done   = (core_cnt >= cur_lat);
            core_result = ref_gcd(core_a, core_b);
        end
    end

    // Scoreboard: results in input order, launches carry the queued operands.
    always @(negedge clk) begin
        pair_t p;
        if (rst) begin
            exp_res_q.delete();
            launch_q.delete();
            prev_start = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_res_q.push_back(ref_gcd(in_a, in_b));
                if (!is_bypassed(in_a, in_b)) begin
                    p.a = in_a;
                    p.b = in_b;
                    launch_q.push_back(p);
                end
            end
            if (res_valid && res_ready) begin
                got_q.push_back(res_data);
                if (exp_res_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    check("sb_result", res_data, exp_res_q.pop_front());
                end
            end
            if (core_start && !prev_start) begin
                launches++;
                if (launch_q.size() == 0) begin
                    check("sb_unexpected_launch", 1, 0);
                end else begin
                    p = launch_q.pop_front();
                    check("launch_a", core_a, p.a);
                    check("launch_b", core_b, p.b);
                end
            end else if (core_start) begin
                check("hold_operands", {core_a, core_b}, {prev_a, prev_b});
            end
            prev_start = core_start;
            prev_a     = core_a;
            prev_b     = core_b;
        end
    end

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_res_q.size() == 0) && !res_valid && !core_start && in_ready;
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t             tbl[9];
        int               hi;
        int               l0;
        int               seen;
        bit               ok;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] exp_list[$];

        tbl[0] = '{8'd12,  8'd18,  5, 8'd6};
        tbl[1] = '{8'd48,  8'd36,  3, 8'd12};
        tbl[2] = '{8'd7,   8'd5,   1, 8'd1};
        tbl[3] = '{8'd9,   8'd9,   2, 8'd9};
        tbl[4] = '{8'd100, 8'd75,  4, 8'd25};
        tbl[5] = '{8'd255, 8'd17,  6, 8'd17};
        tbl[6] = '{8'd128, 8'd96,  2, 8'd32};
        tbl[7] = '{8'd200, 8'd120, 3, 8'd40};
        tbl[8] = '{8'd221, 8'd13,  7, 8'd13};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Single jobs: launch latency, start duration, drain gap, result.
        foreach (tbl[k]) begin
            fixed_lat = tbl[k].lat;
            push_pair(tbl[k].a, tbl[k].b);
            @(negedge clk);
            check("lat_not_yet", core_start, 0);
            @(negedge clk);
            check("lat_launch", core_start, 1);
            hi = 1;
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (!core_start) ok = 1'b1;
                else hi++;
            end
            if (!ok) check("run_timeout", 0, 1);
            check("start_cycles", hi, (tbl[k].lat > 2) ? tbl[k].lat : 2);
            check("res_valid_rise", res_valid, 1);
            check("res_data", res_data, tbl[k].exp);
            @(negedge clk);
            check("drain_low", core_start, 0);
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end

        // Back-to-back with the FIFO filling up behind a running job.
        fixed_lat = 3;
        res_ready = 1'b1;
        got_q.delete();
        l0 = launches;
        push_pair(8'd48, 8'd36);
        push_pair(8'd7, 8'd5);
        push_pair(8'd9, 8'd9);
        @(negedge clk);
        check("b2b_full", in_ready, 0);
        @(posedge clk);
        #1;
        wait_empty();
        check("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_res0", got_q[0], 12);
            check("b2b_res1", got_q[1], 1);
            check("b2b_res2", got_q[2], 9);
        end
        check("b2b_launches", launches - l0, 3);

        // Backpressure: a held result blocks the next launch.
        fixed_lat = 2;
        res_ready = 1'b0;
        l0 = launches;
        push_pair(8'd20, 8'd8);
        push_pair(8'd21, 8'd14);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        if (!ok) check("bp_timeout", 0, 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (core_start) seen++;
        end
        check("bp_no_launch", seen, 0);
        check("bp_launches", launches - l0, 1);
        check("bp_res_data", res_data, 4);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_cleared", res_valid, 0);
        check("bp_not_yet", core_start, 0);
        @(negedge clk);
        check("bp_launch", core_start, 1);
        check("bp_launch_a", core_a, 21);
        @(posedge clk);
        #1;
        wait_empty();

        // Reset in the middle of a long computation with a job still queued.
        fixed_lat = 30;
        push_pair(8'd100, 8'd75);
        push_pair(8'd3, 8'd6);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("mid_run_start", core_start, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_core_start", core_start, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_core_a", core_a, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (core_start || res_valid) seen++;
        end
        check("mid_rst_fifo_empty", seen, 0);
        @(posedge clk);
        #1;

        // Zero operands: bypassed or passed to the core depending on the build.
        fixed_lat = 2;
        got_q.delete();
        l0 = launches;
        res_ready = 1'b1;
        push_pair(8'd0, 8'd15);
        push_pair(8'd0, 8'd0);
        wait_empty();
        check("zero_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("zero_res0", got_q[0], 15);
            check("zero_res1", got_q[1], 0);
        end
`ifdef GCD_ZERO_BYPASS_EN
        check("zero_launches", launches - l0, 0);
`else
        check("zero_launches", launches - l0, 2);
`endif

        // Stream held at the FIFO limit: nothing lost, nothing duplicated.
        got_q.delete();
        exp_list.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ra = 8'(30 + 7 * i);
            rb = 8'(42 + 14 * i);
            exp_list.push_back(ref_gcd(ra, rb));
            push_pair(ra, rb);
        end
        wait_empty();
        check("stream_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            check("stream_res", got_q[i], exp_list[i]);
        end

        // Random stream with random core latency and consumer stalls.
        fixed_lat = 0;
        got_q.delete();
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    push_pair(ra, rb);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    res_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        wait_empty();
        check("random_count", got_q.size(), 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
